// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//
// Runtime-configurable UART receiver. The frame format and the baud divisor
// come from config_data and are captured into a shadow register when a start
// bit is seen, so the format stays fixed for the whole frame. A received word
// is held in a one-entry holding register with a valid/ready handshake,
// together with its framing, parity and break status.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : the PARITY state and parity checking are built.
//   undefined : config_data[29:28] is ignored, frames are always N and
//               o_Parity_Err is tied to 0.
//
// Parameters
//   UART_DATA_WIDTH      maximum data bits per frame (5..9), o_Rx_Data width
//   CONFIG_DATA_WIDTH    config word width
//   DEFAULT_CLKS_PER_BIT divisor used from reset until the first frame
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Rx_Serial   asynchronous serial line, idle high
//   config_data   [23:0] clocks per bit, [27:24] data bits,
//                 [29:28] parity (00/11 none, 01 even, 10 odd),
//                 [30] two stop bits, [31] reserved
//   i_Rx_Ready    consumer accepts the held word
//   o_Rx_Valid    holding register full
//   o_Rx_Data     received word, zero-extended above the configured length
//   o_Frame_Err   stop bit sampled low (stored with the word)
//   o_Parity_Err  parity mismatch (stored with the word)
//   o_Break       all-zero frame including stop bits (stored with the word)
//   o_Overrun     one-cycle pulse when a completed frame is dropped
//   o_Busy        receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int UART_DATA_WIDTH      = 8,
   parameter int CONFIG_DATA_WIDTH    = 32,
   parameter int DEFAULT_CLKS_PER_BIT = 437
) (
   input  logic                         i_Clock,
   input  logic                         i_Rst_n,
   input  logic                         i_Rx_Serial,
   input  logic [CONFIG_DATA_WIDTH-1:0] config_data,
   input  logic                         i_Rx_Ready,
   output logic                         o_Rx_Valid,
   output logic [UART_DATA_WIDTH-1:0]   o_Rx_Data,
   output logic                         o_Frame_Err,
   output logic                         o_Parity_Err,
   output logic                         o_Break,
   output logic                         o_Overrun,
   output logic                         o_Busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t                     r_state;
   state_t                     w_next_state;

   logic                       r_sync1;
   logic                       r_sync2;

   logic [23:0]                r_cnt;
   logic [3:0]                 r_idx;
   logic [UART_DATA_WIDTH-1:0] r_shift;

   // Shadow copy of the frame format, held for the whole frame.
   logic [23:0]                r_div;
   logic [3:0]                 r_nbits;
   logic                       r_two;

   logic                       r_stop_low;
   logic                       r_stop_high;
   logic                       r_stop_second;

   logic                       r_valid;
   logic [UART_DATA_WIDTH-1:0] r_data;
   logic                       r_ferr;
   logic                       r_perr;
   logic                       r_brk;
   logic                       r_ovr;

   logic [23:0]                w_cfg_div;
   logic [3:0]                 w_cfg_nbits;
   logic [23:0]                w_half;
   logic [23:0]                w_last;
   logic                       w_cnt_half;
   logic                       w_cnt_full;
   logic                       w_last_bit;
   logic                       w_final_stop;
   logic                       w_done;
   logic                       w_retire;
   logic                       w_frame_err;
   logic                       w_all_stops_low;
   logic                       w_par_err;
   logic                       w_par_low_ok;
   logic                       w_break;
   logic                       w_unused_cfg;

`ifdef UART_RX_PARITY_EN
   logic [1:0]                 r_par_mode;
   logic                       r_par_bit;
   logic                       w_par_en;
   logic                       w_par_xor;

   assign w_par_en     = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
   assign w_par_xor    = (^r_shift) ^ r_par_bit;
   assign w_par_err    = (r_par_mode == 2'b01) ? w_par_xor :
                         (r_par_mode == 2'b10) ? ~w_par_xor : 1'b0;
   assign w_par_low_ok = ~w_par_en | ~r_par_bit;
   assign w_unused_cfg = config_data[CONFIG_DATA_WIDTH-1];
`else
   assign w_par_err    = 1'b0;
   assign w_par_low_ok = 1'b1;
   assign w_unused_cfg = ^{config_data[CONFIG_DATA_WIDTH-1], config_data[29:28]};
`endif

   // Clamp the incoming config before it is captured.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_cfg_div   = config_data[23:0];
      w_cfg_nbits = config_data[27:24];
      if (config_data[23:0] < 24'd4) begin
         w_cfg_div = 24'd4;
      end
      if (config_data[27:24] < 4'd5) begin
         w_cfg_nbits = 4'd5;
      end else if (config_data[27:24] > 4'(UART_DATA_WIDTH)) begin
         w_cfg_nbits = 4'(UART_DATA_WIDTH);
      end
   end

   assign w_half       = (r_div - 24'd1) >> 1;
   assign w_last       = r_div - 24'd1;
   assign w_cnt_half   = (r_cnt == w_half);
   assign w_cnt_full   = (r_cnt == w_last);
   assign w_last_bit   = (r_idx == (r_nbits - 4'd1));
   assign w_final_stop = r_two ? r_stop_second : 1'b1;
   assign w_done       = (r_state == S_STOP) && w_cnt_full && w_final_stop;
   assign w_retire     = r_valid && i_Rx_Ready;

   // Status of the frame completing this cycle; the final stop sample is the
   // live synchroniser output, earlier stop samples are in r_stop_low/high.
   assign w_frame_err     = r_stop_low | ~r_sync2;
   assign w_all_stops_low = ~r_stop_high & ~r_sync2;
   assign w_break         = (r_shift == '0) & w_par_low_ok & w_all_stops_low;

   // Two-flop synchroniser, idle-high reset so no false start after reset.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the pre-edge value of the others.
         r_sync1 <= i_Rx_Serial;
         r_sync2 <= r_sync1;
      end
   end

   // FSM: state register.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM: next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (!r_sync2) begin
               w_next_state = S_START;
            end
         end
         S_START: begin
            // Line back high at mid start bit is a glitch: drop silently.
            if (w_cnt_half) begin
               w_next_state = r_sync2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_cnt_full && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
               w_next_state = w_par_en ? S_PARITY : S_STOP;
`else
               w_next_state = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_cnt_full) begin
               w_next_state = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_done) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // FSM: outputs.
   always_comb begin
      o_Busy       = (r_state != S_IDLE);
      o_Rx_Valid   = r_valid;
      o_Rx_Data    = r_data;
      o_Frame_Err  = r_ferr;
      o_Parity_Err = r_perr;
      o_Break      = r_brk;
      o_Overrun    = r_ovr;
   end

   // Bit-timing counter, shadow config and sample capture.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shift       <= '0;
         r_div         <= 24'(DEFAULT_CLKS_PER_BIT);
         r_nbits       <= 4'(UART_DATA_WIDTH);
         r_two         <= 1'b0;
         r_stop_low    <= 1'b0;
         r_stop_high   <= 1'b0;
         r_stop_second <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_mode    <= 2'b00;
         r_par_bit     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt         <= '0;
               r_idx         <= '0;
               r_stop_low    <= 1'b0;
               r_stop_high   <= 1'b0;
               r_stop_second <= 1'b0;
               if (!r_sync2) begin
                  r_div   <= w_cfg_div;
                  r_nbits <= w_cfg_nbits;
                  r_two   <= config_data[30];
                  r_shift <= '0;
`ifdef UART_RX_PARITY_EN
                  r_par_mode <= config_data[29:28];
`endif
               end
            end
            S_START: begin
               r_cnt <= w_cnt_half ? '0 : r_cnt + 24'd1;
            end
            S_DATA: begin
               if (w_cnt_full) begin
                  // Bits outside the configured length stay 0 (zero-extend).
                  r_shift <= r_shift | ({{(UART_DATA_WIDTH-1){1'b0}}, r_sync2} << r_idx);
                  r_idx   <= r_idx + 4'd1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 24'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_cnt_full) begin
                  r_par_bit <= r_sync2;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + 24'd1;
               end
            end
`endif
            S_STOP: begin
               if (w_cnt_full) begin
                  r_cnt         <= '0;
                  r_stop_second <= 1'b1;
                  if (r_sync2) begin
                     r_stop_high <= 1'b1;
                  end else begin
                     r_stop_low <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 24'd1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Holding register and handshake. A retire in the completion cycle frees
   // the slot, so the new word loads without an overrun.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ferr  <= 1'b0;
         r_perr  <= 1'b0;
         r_brk   <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         if (w_done) begin
            if (!r_valid || w_retire) begin
               r_valid <= 1'b1;
               r_data  <= r_shift;
               r_ferr  <= w_frame_err;
               r_perr  <= w_par_err;
               r_brk   <= w_break;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (w_retire) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Self-checking bench for uart_rx_cfg. A reference model predicts the
// receiver from the line alone: the synchronised line is the line two edges
// earlier, a start is seen by an idle receiver, and every sample of a frame
// falls at start + 1 + (div-1)/2 + k*div. The holding register follows the
// valid/ready rules. Outputs are compared on every falling edge; a few
// hand-computed values pin the model. Honours UART_RX_PARITY_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

   localparam int UW = 8;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif

   logic          i_Clock;
   logic          i_Rst_n;
   logic          i_Rx_Serial;
   logic [31:0]   config_data;
   logic          i_Rx_Ready;
   logic          o_Rx_Valid;
   logic [UW-1:0] o_Rx_Data;
   logic          o_Frame_Err;
   logic          o_Parity_Err;
   logic          o_Break;
   logic          o_Overrun;
   logic          o_Busy;

   uart_rx_cfg #(
      .UART_DATA_WIDTH      (UW),
      .CONFIG_DATA_WIDTH    (32),
      .DEFAULT_CLKS_PER_BIT (437)
   ) dut (
      .i_Clock      (i_Clock),
      .i_Rst_n      (i_Rst_n),
      .i_Rx_Serial  (i_Rx_Serial),
      .config_data  (config_data),
      .i_Rx_Ready   (i_Rx_Ready),
      .o_Rx_Valid   (o_Rx_Valid),
      .o_Rx_Data    (o_Rx_Data),
      .o_Frame_Err  (o_Frame_Err),
      .o_Parity_Err (o_Parity_Err),
      .o_Break      (o_Break),
      .o_Overrun    (o_Overrun),
      .o_Busy       (o_Busy)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Frame format as the receiver interprets a config word.
   function automatic int eff_div(input logic [31:0] c);
      return (c[23:0] < 24'd4) ? 4 : int'(c[23:0]);
   endfunction
   function automatic int eff_nb(input logic [31:0] c);
      int n;
      n = int'(c[27:24]);
      if (n < 5) n = 5;
      if (n > UW) n = UW;
      return n;
   endfunction
   function automatic int eff_pm(input logic [31:0] c);
      if (!PAR_BUILT) return 0;
      if (c[29:28] == 2'b01) return 1;
      if (c[29:28] == 2'b10) return 2;
      return 0;
   endfunction
   function automatic int eff_ns(input logic [31:0] c);
      return c[30] ? 2 : 1;
   endfunction
   function automatic logic [31:0] mk_cfg(input int div, input int nb, input int pm, input int ns);
      return {1'b0, (ns == 2), 2'(pm), 4'(nb), 24'(div)};
   endfunction

   // ---------------- reference model ----------------
   int  cyc = 0;
   bit  h1 = 1'b1, h2 = 1'b1;
   bit  m_rx = 1'b0;
   int  m_e0, m_k, m_len, m_div, m_nb, m_pm, m_ns;
   bit  m_samp [0:15];
   bit  m_valid = 0, m_busy = 0, m_ovr = 0, m_ferr = 0, m_perr = 0, m_brk = 0;
   int  m_data = 0;
   bit  md_sync, md_retire, md_done, md_pb, md_low, md_all_low, md_x;
   int  md_fd;

   always @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         h1 = 1'b1; h2 = 1'b1; m_rx = 1'b0;
         m_valid = 0; m_busy = 0; m_ovr = 0; m_ferr = 0; m_perr = 0; m_brk = 0; m_data = 0;
      end else begin
         cyc++;
         md_sync = h2; h2 = h1; h1 = i_Rx_Serial;
         md_retire = m_valid && i_Rx_Ready;
         md_done = 0;
         m_ovr = 0;
         if (m_rx) begin
            if (cyc == m_e0 + 1 + ((m_div - 1) >> 1) + m_div * m_k) begin
               m_samp[m_k] = md_sync;
               m_k++;
               if (m_k == 1 && md_sync) m_rx = 0;
               else if (m_k == m_len) begin m_rx = 0; md_done = 1; end
            end
         end else if (!md_sync) begin
            m_rx = 1; m_e0 = cyc; m_k = 0;
            m_div = eff_div(config_data); m_nb = eff_nb(config_data);
            m_pm = eff_pm(config_data); m_ns = eff_ns(config_data);
            m_len = 1 + m_nb + ((m_pm != 0) ? 1 : 0) + m_ns;
         end
         m_busy = m_rx;
         if (md_done) begin
            md_fd = 0;
            for (int i = 0; i < m_nb; i++) md_fd |= int'(m_samp[1 + i]) << i;
            md_pb = (m_pm != 0) ? m_samp[1 + m_nb] : 1'b0;
            md_low = 0; md_all_low = 1;
            for (int i = m_len - m_ns; i < m_len; i++) begin
               if (!m_samp[i]) md_low = 1; else md_all_low = 0;
            end
            md_x = (^md_fd) ^ md_pb;
            if (!m_valid || md_retire) begin
               m_valid = 1;
               m_data  = md_fd;
               m_perr  = (m_pm == 1) ? md_x : (m_pm == 2) ? !md_x : 1'b0;
               m_brk   = (md_fd == 0) && (m_pm == 0 || !md_pb) && md_all_low;
               m_ferr  = md_low || m_brk;
            end else begin
               m_ovr = 1;
            end
         end else if (md_retire) begin
            m_valid = 0;
         end
      end
   end

   // ---------------- cycle compare ----------------
   bit prev_v = 0;
   int rise_cyc = 0;
   int ovr_cnt = 0;

   always @(negedge i_Clock) begin
      check("valid", o_Rx_Valid, m_valid);
      check("busy", o_Busy, m_busy);
      check("overrun", o_Overrun, m_ovr);
      if (m_valid) begin
         check("data", o_Rx_Data, m_data);
         check("frame_err", o_Frame_Err, m_ferr);
         check("parity_err", o_Parity_Err, m_perr);
         check("break", o_Break, m_brk);
      end
      if (o_Rx_Valid && !prev_v) rise_cyc = cyc;
      prev_v = o_Rx_Valid;
      if (o_Overrun) ovr_cnt++;
   end

   // ---------------- stimulus ----------------
   int fall_cyc = 0;

   // Drives one frame from the phase 1 time unit after a rising edge.
   // rdy_mode: 0 leave ready alone, 1 random ready, 2 ready only for the
   // cycle that ends in the final stop sample.
   task automatic send_frame(input logic [31:0] c, input int data, input bit par_flip,
                             input bit s1_low, input bit s2_low, input int gap, input int rdy_mode);
      int div, nb, pm, ns, total, foff;
      bit p;
      bit q[$];
      div = eff_div(c); nb = eff_nb(c); pm = eff_pm(c); ns = eff_ns(c);
      q.push_back(1'b0);
      p = 1'b0;
      for (int i = 0; i < nb; i++) begin
         q.push_back(1'((data >> i) & 1));
         p ^= 1'((data >> i) & 1);
      end
      if (pm != 0) begin
         if (pm == 2) p = !p;
         q.push_back(p ^ par_flip);
      end
      q.push_back(!s1_low);
      if (ns == 2) q.push_back(!s2_low);
      total = q.size() * div;
      foff = 4 + ((div - 1) >> 1) + div * (q.size() - 1);
      config_data = c;
      fall_cyc = cyc;
      for (int t = 0; t < total + gap; t++) begin
         i_Rx_Serial = (t < total) ? q[t / div] : 1'b1;
         if (rdy_mode == 1) i_Rx_Ready = 1'($urandom_range(0, 1));
         if (rdy_mode == 2) i_Rx_Ready = (t == foff - 1);
         @(posedge i_Clock); #1;
      end
   endtask

   task automatic retire();
      i_Rx_Ready = 1'b1;
      @(posedge i_Clock); #1;
      i_Rx_Ready = 1'b0;
      check("retired", o_Rx_Valid, 1'b0);
   endtask

   initial begin
      logic [31:0] c;
      int inj, d;
      i_Rst_n = 1'b0; i_Rx_Serial = 1'b1; i_Rx_Ready = 1'b0;
      config_data = mk_cfg(16, 8, 0, 1);
      @(posedge i_Clock); #1;
      check("rst_valid", o_Rx_Valid, 1'b0);
      check("rst_busy", o_Busy, 1'b0);
      check("rst_data", o_Rx_Data, 0);
      check("rst_overrun", o_Overrun, 1'b0);
      repeat (2) @(posedge i_Clock);
      #1 i_Rst_n = 1'b1;
      repeat (3) @(posedge i_Clock);
      #1;

      // 8N1, div 16: 0xA5, valid 155 edges after the line falls.
      send_frame(mk_cfg(16, 8, 0, 1), 'hA5, 0, 0, 0, 20, 0);
      check("a5_data", o_Rx_Data, 'hA5);
      check("a5_valid", o_Rx_Valid, 1'b1);
      check("a5_errs", {o_Frame_Err, o_Parity_Err, o_Break}, 0);
      check("a5_latency", rise_cyc - fall_cyc, 155);
      retire();

      // 7 bits, even parity: correct then wrong parity bit.
      send_frame(mk_cfg(16, 7, 1, 1), 'h35, 0, 0, 0, 20, 0);
      check("p_ok_data", o_Rx_Data, 'h35);
      check("p_ok_perr", o_Parity_Err, 1'b0);
      retire();
      send_frame(mk_cfg(16, 7, 1, 1), 'h35, 1, 0, 0, 20, 0);
      check("p_bad_data", o_Rx_Data, 'h35);
      check("p_bad_perr", o_Parity_Err, PAR_BUILT);
      retire();

      // 8N2: second stop low, then an all-zero break frame.
      send_frame(mk_cfg(16, 8, 0, 2), 'h3C, 0, 0, 1, 40, 0);
      check("s2_data", o_Rx_Data, 'h3C);
      check("s2_ferr", o_Frame_Err, 1'b1);
      check("s2_break", o_Break, 1'b0);
      retire();
      send_frame(mk_cfg(16, 8, 0, 2), 0, 0, 1, 1, 40, 0);
      check("brk_break", o_Break, 1'b1);
      check("brk_ferr", o_Frame_Err, 1'b1);
      check("brk_data", o_Rx_Data, 0);
      retire();

      // Overrun with ready low, then a retire exactly on completion.
      send_frame(mk_cfg(16, 8, 0, 1), 'h11, 0, 0, 0, 20, 0);
      send_frame(mk_cfg(16, 8, 0, 1), 'h22, 0, 0, 0, 20, 0);
      check("ovr_count", ovr_cnt, 1);
      check("ovr_keep", o_Rx_Data, 'h11);
      send_frame(mk_cfg(16, 8, 0, 1), 'h33, 0, 0, 0, 20, 2);
      check("swap_data", o_Rx_Data, 'h33);
      check("swap_valid", o_Rx_Valid, 1'b1);
      check("swap_no_ovr", ovr_cnt, 1);
      retire();

      // Short low glitch is ignored; divisor 2 behaves as 4.
      config_data = mk_cfg(16, 8, 0, 1);
      i_Rx_Serial = 1'b0;
      repeat (4) begin @(posedge i_Clock); #1; end
      i_Rx_Serial = 1'b1;
      repeat (40) begin @(posedge i_Clock); #1; end
      check("glitch_valid", o_Rx_Valid, 1'b0);
      check("glitch_busy", o_Busy, 1'b0);
      send_frame(mk_cfg(2, 8, 0, 1), 'h96, 0, 0, 0, 12, 0);
      check("div2_data", o_Rx_Data, 'h96);

      // Reset mid-DATA with a word still held.
      config_data = mk_cfg(16, 8, 0, 1);
      i_Rx_Serial = 1'b0;
      repeat (16 * 3 + 5) begin @(posedge i_Clock); #1; end
      check("mid_busy", o_Busy, 1'b1);
      i_Rst_n = 1'b0;
      #1;
      check("mr_valid", o_Rx_Valid, 1'b0);
      check("mr_data", o_Rx_Data, 0);
      check("mr_busy", o_Busy, 1'b0);
      i_Rx_Serial = 1'b1;
      repeat (3) @(posedge i_Clock);
      #1 i_Rst_n = 1'b1;
      repeat (5) begin @(posedge i_Clock); #1; end
      send_frame(mk_cfg(16, 8, 0, 1), 'h5A, 0, 0, 0, 20, 0);
      check("post_rst_data", o_Rx_Data, 'h5A);
      check("post_rst_valid", o_Rx_Valid, 1'b1);
      retire();

      // Random formats, data, error injection and ready.
      for (int f = 0; f < 40; f++) begin
         c = '0;
         c[23:0]  = 24'($urandom_range(0, 20));
         c[27:24] = 4'($urandom_range(0, 15));
         c[29:28] = 2'($urandom_range(0, 3));
         c[30]    = 1'($urandom_range(0, 1));
         c[31]    = 1'($urandom_range(0, 1));
         inj = $urandom_range(0, 7);
         d = (inj == 4) ? 0 : $urandom_range(0, 511);
         send_frame(c, d, inj == 1, inj == 2 || inj == 4, inj == 3 || inj == 4,
                    eff_div(c) + $urandom_range(0, 2 * eff_div(c)), 1);
      end

      i_Rx_Ready = 1'b1;
      repeat (10) @(posedge i_Clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
